// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: queue depth, queue entry layout and fetch FSM encoding.
package cpu_pkg;

  localparam int FQ_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries; clear wins over push/pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t        mem_q [DEPTH];
  logic [AW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [AW:0]         count_q, count_d;

  // Pointers wrap for free since DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + 1'b1;
      if (pop_i)  head_d = head_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[tail_q] <= push_data_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: one-outstanding imem request FSM feeding a small
// in-order queue toward decode, with flush handling for a response still in flight.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  input  logic        dec_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [CW-1:0] count;
  logic         full, accept, push, pop;
  fetch_entry_t head, push_data;

  // Issue only when a slot is free, so the eventual push can never overflow.
  assign full           = (count == CW'(DEPTH));
  assign imem_req_valid = !rst && (state_q == REQ) && !full && !flush;
  assign imem_req_addr  = {pc[31:2], 2'b00};
  assign accept         = imem_req_valid && imem_req_ready;
  assign stall          = ~accept;

  assign push      = (state_q == WAIT) && imem_resp_valid && !flush;
  assign dec_valid = !rst && (count != '0);
  assign pop       = dec_valid && dec_ready && !flush;
  assign push_data = '{pc: req_pc_q, instr: imem_resp_data};
  assign dec_pc    = head.pc;
  assign dec_instr = head.instr;

  // A flush while waiting must still swallow the stale response before reissuing.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      REQ: if (accept) begin
        state_d  = WAIT;
        req_pc_d = pc;
      end
      WAIT: begin
        if (imem_resp_valid) state_d = REQ;
        else if (flush)      state_d = DRAIN;
      end
      DRAIN: if (imem_resp_valid) state_d = REQ;
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (flush),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: pc_gen and imem models drive the DUT, a
// monitor checks every decode pop against expected entries.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        flush = 1'b0;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        dec_valid;
  logic [31:0] dec_pc, dec_instr;
  logic        dec_ready = 1'b0;

  ifetch_queue #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .flush           (flush),
    .stall           (stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_pc          (dec_pc),
    .dec_instr       (dec_instr),
    .dec_ready       (dec_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [31:0] acc_log[$];
  int          lat = 1;
  int          mode = 0;
  logic [31:0] flush_pc = 32'h0;
  bit          inflight = 0, drained = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_pc, pend_data;
  bit          seq_chk = 0;
  logic [31:0] last_pc = 32'h0;
  int          pops = 0;
  bit          s_rst, s_acc, s_resp, s_flush;
  logic [31:0] s_addr;
  bit          g_rst, g_stall, g_flush;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    case (mode)
      0:       return 32'h0000_0013;
      1:       return {a[23:0], 8'h13};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // imem model plus expected-entry generation; sampled at negedge, applied at posedge.
  always begin
    @(negedge clk);
    s_rst   = rst;
    s_acc   = imem_req_valid && imem_req_ready;
    s_addr  = imem_req_addr;
    s_resp  = imem_resp_valid;
    s_flush = flush;
    @(posedge clk);
    if (s_rst) begin
      sb.delete();
      inflight = 0;
      drained  = 0;
      pend_cnt = 0;
    end else begin
      if (inflight && s_resp) begin
        if (!s_flush && !drained) sb.push_back('{pend_pc, pend_data});
        inflight = 0;
      end else if (inflight && s_flush) begin
        drained = 1;
      end
      if (s_flush) sb.delete();
      if (s_acc) begin
        acc_log.push_back(s_addr);
        inflight  = 1;
        drained   = 0;
        pend_cnt  = lat;
        pend_pc   = s_addr;
        pend_data = data_of(s_addr);
      end
    end
    #1;
    imem_resp_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = pend_data;
      end
    end
  end

  // pc_gen: redirect on flush, advance once per accepted request.
  always begin
    @(negedge clk);
    g_rst   = rst;
    g_stall = stall;
    g_flush = flush;
    @(posedge clk);
    #1;
    if (g_rst)        pc = 32'h0;
    else if (g_flush) pc = flush_pc;
    else if (!g_stall) pc = pc + 32'd4;
  end

  // Monitor: occupancy, issue limit and every pop against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("dec_valid_vs_model", dec_valid, sb.size() != 0);
      if (sb.size() >= 4) check("no_issue_when_full", imem_req_valid, 1'b0);
      if (dec_valid && dec_ready && !flush && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("pop_pc", dec_pc, e.pc);
        check("pop_instr", dec_instr, e.instr);
        if (seq_chk) begin
          check("seq_pc", dec_pc, last_pc + 32'd4);
          last_pc = dec_pc;
        end
        pops++;
      end
    end
  end

  task automatic wait_acc(input int n0);
    for (int i = 0; i < 50 && acc_log.size() <= n0; i++) begin
      @(posedge clk);
      #1;
    end
    check("accept_seen", acc_log.size() > n0, 1'b1);
  endtask

  initial begin
    int n, n0;
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_dec_valid", dec_valid, 1'b0);
    check("rst_stall", stall, 1'b1);
    @(posedge clk); #1 rst = 1'b0;

    // Fill: one stall-low cycle per accept, four entries 0x0..0xC
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (!stall) n++;
    end
    check("fill_accepts", n, 4);
    check("fill_log_size", acc_log.size(), 4);
    if (acc_log.size() >= 4) begin
      check("fill_addr0", acc_log[0], 32'h0);
      check("fill_addr1", acc_log[1], 32'h4);
      check("fill_addr2", acc_log[2], 32'h8);
      check("fill_addr3", acc_log[3], 32'hC);
    end
    check("full_req_valid", imem_req_valid, 1'b0);
    check("full_stall", stall, 1'b1);
    check("full_head_pc", dec_pc, 32'h0);
    check("full_head_instr", dec_instr, 32'h0000_0013);

    // One pop from full: one refill request
    @(posedge clk); #1 dec_ready = 1'b1;
    @(posedge clk); #1 dec_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("refill_log_size", acc_log.size(), 5);
    if (acc_log.size() >= 5) check("refill_addr", acc_log[4], 32'h10);
    check("refill_req_valid", imem_req_valid, 1'b0);
    check("refill_head_pc", dec_pc, 32'h4);

    // Flush with response outstanding: DRAIN swallows 0xDEADBEEF
    mode = 2; lat = 3;
    @(posedge clk); #1 flush_pc = 32'h10; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    n0 = acc_log.size();
    wait_acc(n0);
    if (acc_log.size() > n0) check("drain_req_addr", acc_log[n0], 32'h10);
    flush_pc = 32'h2000; flush = 1'b1; mode = 1; lat = 1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("drain_dec_valid", dec_valid, 1'b0);
    end
    n0 = acc_log.size();
    wait_acc(n0);
    if (acc_log.size() > n0) check("redirect_addr", acc_log[n0], 32'h2000);
    repeat (2) @(negedge clk);
    check("redirect_dec_valid", dec_valid, 1'b1);
    check("redirect_pc", dec_pc, 32'h2000);
    check("redirect_instr", dec_instr, 32'h0020_0013);

    // Flush coincident with the response
    repeat (12) @(posedge clk);
    #1 flush_pc = 32'h2800; flush = 1'b1; lat = 2;
    @(posedge clk); #1 flush = 1'b0;
    n0 = acc_log.size();
    wait_acc(n0);
    if (acc_log.size() > n0) check("coinc_req_addr", acc_log[n0], 32'h2800);
    @(posedge clk); #1 flush_pc = 32'h3000; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; imem_req_ready = 1'b0;
    @(negedge clk);
    check("coinc_dec_valid", dec_valid, 1'b0);
    check("coinc_req_valid", imem_req_valid, 1'b1);
    check("coinc_req_addr2", imem_req_addr, 32'h3000);

    // Memory not ready for 5 cycles
    repeat (5) begin
      @(negedge clk);
      check("nrdy_stall", stall, 1'b1);
      check("nrdy_addr", imem_req_addr, 32'h3000);
      check("nrdy_dec_valid", dec_valid, 1'b0);
    end
    @(posedge clk); #1 imem_req_ready = 1'b1; lat = 1;

    // Random decode backpressure over 100 instructions
    pops = 0; last_pc = 32'h2FFC; seq_chk = 1;
    for (int i = 0; i < 3000 && pops < 100; i++) begin
      @(posedge clk);
      #1 dec_ready = 1'($urandom_range(0, 1));
    end
    check("random_pops_done", pops >= 100, 1'b1);
    dec_ready = 1'b0; seq_chk = 0;

    // Reset mid-stream
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst2_req_valid", imem_req_valid, 1'b0);
    check("rst2_dec_valid", dec_valid, 1'b0);
    check("rst2_stall", stall, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_reissue", imem_req_valid, 1'b1);
    check("rst2_addr", imem_req_addr, 32'h0);
    check("rst2_empty", dec_valid, 1'b0);
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
